// File: rtl/board_debug_ctrl.sv
// Board debug controller: debounces the four push buttons, produces the CPU
// clock-enable in single-step or free-run mode, selects the probe word shown
// on the 7-segment display and counts executed steps for the LEDs.
// There is no valid/ready traffic here: every internal event is a one-cycle
// pulse, and the run state is visible on run_active, which mirrors the FSM.
module board_debug_ctrl #(
    parameter int DATA_W       = 32,
    parameter int NUM_VIEWS    = 7,
    parameter int DEBOUNCE_CYC = 100000,
    parameter int RUN_DIV      = 5000000,
    parameter int CNT_W        = 16,
    localparam int SEL_W       = $clog2(NUM_VIEWS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        btn_step,
    input  logic                        btn_mode,
    input  logic                        btn_next,
    input  logic                        btn_prev,
    input  logic [NUM_VIEWS*DATA_W-1:0] view_data,
    output logic                        cpu_ce,
    output logic                        run_active,
    output logic [SEL_W-1:0]            view_sel,
    output logic [DATA_W-1:0]           disp_data,
    output logic [CNT_W-1:0]            step_count
);

    localparam int NB    = 4;
    localparam int DBC_W = $clog2(DEBOUNCE_CYC);
    localparam int DIV_W = $clog2(RUN_DIV);

    // Button bit positions inside the packed debounce vectors
    localparam int B_STEP = 0;
    localparam int B_MODE = 1;
    localparam int B_NEXT = 2;
    localparam int B_PREV = 3;

    typedef enum logic {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    rise;
    logic [DBC_W-1:0] db_cnt [NB];

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DATA_W-1:0] view_word;

    logic step_p;
    logic mode_p;
    logic next_p;
    logic prev_p;

    assign raw    = {btn_prev, btn_next, btn_mode, btn_step};
    assign step_p = rise[B_STEP];
    assign mode_p = rise[B_MODE];
    assign next_p = rise[B_NEXT];
    assign prev_p = rise[B_PREV];

    // Synchronise, debounce and edge-detect every button; a level is accepted
    // only after DEBOUNCE_CYC consecutive cycles of disagreement with stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            rise     <= '0;
            for (int b = 0; b < NB; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            rise     <= stable & ~stable_q;
            for (int b = 0; b < NB; b++) begin
                if (sync2[b] == stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DBC_W'(DEBOUNCE_CYC - 1)) begin
                    stable[b] <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // STEP/RUN control FSM; a mode pulse always wins over step and divider events.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_STEP;
            div_cnt    <= '0;
            cpu_ce     <= 1'b0;
            run_active <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                ST_STEP: begin
                    if (mode_p) begin
                        state      <= ST_RUN;
                        div_cnt    <= '0;
                        run_active <= 1'b1;
                    end else if (step_p) begin
                        cpu_ce <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mode_p) begin
                        state      <= ST_STEP;
                        div_cnt    <= '0;
                        run_active <= 1'b0;
                    end else if (div_cnt == DIV_W'(RUN_DIV - 1)) begin
                        div_cnt <= '0;
                        cpu_ce  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Count issued clock-enables; the counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_count <= '0;
        end else if (cpu_ce) begin
            step_count <= step_count + 1'b1;
        end
    end

    // Step the view index with wrap-around; opposing pulses cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            view_sel <= '0;
        end else if (next_p && !prev_p) begin
            view_sel <= (view_sel == SEL_W'(NUM_VIEWS - 1)) ? '0 : view_sel + 1'b1;
        end else if (prev_p && !next_p) begin
            view_sel <= (view_sel == '0) ? SEL_W'(NUM_VIEWS - 1) : view_sel - 1'b1;
        end
    end

    // Mux the probe word addressed by view_sel.
    always_comb begin
        view_word = '0;
        for (int k = 0; k < NUM_VIEWS; k++) begin
            if (view_sel == SEL_W'(k)) begin
                view_word = view_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Register the displayed word so the display path starts from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data <= '0;
        end else begin
            disp_data <= view_word;
        end
    end

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Directed-plus-random bench for board_debug_ctrl. Expected values come from
// the documented timing rules (press-to-effect latency, RUN period, wrap rules)
// evaluated with plain arithmetic on cycle numbers and a view-index model.
module tb_board_debug_ctrl;

  localparam int DATA_W       = 32;
  localparam int NUM_VIEWS    = 7;
  localparam int DEBOUNCE_CYC = 4;
  localparam int RUN_DIV      = 5;
  localparam int CNT_W        = 16;
  localparam int SEL_W        = $clog2(NUM_VIEWS);
  // raw edge -> pulse-driven effect (cpu_ce or view_sel update)
  localparam int PRESS_LAT    = DEBOUNCE_CYC + 4;

  localparam logic [3:0] M_STEP = 4'b0001;
  localparam logic [3:0] M_MODE = 4'b0010;
  localparam logic [3:0] M_NEXT = 4'b0100;
  localparam logic [3:0] M_PREV = 4'b1000;

  logic                        clk;
  logic                        rst;
  logic                        btn_step;
  logic                        btn_mode;
  logic                        btn_next;
  logic                        btn_prev;
  logic [NUM_VIEWS*DATA_W-1:0] view_data;
  logic                        cpu_ce;
  logic                        run_active;
  logic [SEL_W-1:0]            view_sel;
  logic [DATA_W-1:0]           disp_data;
  logic [CNT_W-1:0]            step_count;

  // reference state
  logic [DATA_W-1:0] words [NUM_VIEWS];
  int                exp_vs;
  int                exp_steps;
  int                cycle;
  int                ce_log[$];

  int pass_cnt;
  int total_cnt;

  board_debug_ctrl #(
    .DATA_W      (DATA_W),
    .NUM_VIEWS   (NUM_VIEWS),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .RUN_DIV     (RUN_DIV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .view_data (view_data),
    .cpu_ce    (cpu_ce),
    .run_active(run_active),
    .view_sel  (view_sel),
    .disp_data (disp_data),
    .step_count(step_count)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // one clock edge, sample 1 time unit later, log cpu_ce pulses by edge number
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (cpu_ce === 1'b1) ce_log.push_back(cycle);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_words();
    for (int k = 0; k < NUM_VIEWS; k++) begin
      words[k] = $urandom;
      view_data[k*DATA_W +: DATA_W] = words[k];
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int idle);
    {btn_prev, btn_next, btn_mode, btn_step} = mask;
    repeat (hold) tick();
    {btn_prev, btn_next, btn_mode, btn_step} = 4'b0000;
    repeat (idle) tick();
  endtask

  task automatic view_press(input bit go_next);
    press(go_next ? M_NEXT : M_PREV, $urandom_range(DEBOUNCE_CYC, 10), 12);
    exp_vs = go_next ? (exp_vs + 1) % NUM_VIEWS : (exp_vs + NUM_VIEWS - 1) % NUM_VIEWS;
    chk(go_next ? "next_sel" : "prev_sel", view_sel, exp_vs);
    chk("view_disp", disp_data, words[exp_vs]);
  endtask

  // compare logged RUN pulses against entry+k*RUN_DIV for all k>=1 before exit_e
  task automatic check_run(input int entry, input int exit_e);
    int n_exp;
    n_exp = 0;
    while (entry + RUN_DIV * (n_exp + 1) < exit_e) n_exp++;
    chk("run_pulse_count", ce_log.size(), n_exp);
    for (int i = 0; i < n_exp && i < ce_log.size(); i++) begin
      chk("run_pulse_time", ce_log[i], entry + RUN_DIV * (i + 1));
    end
    exp_steps = (exp_steps + n_exp) % (1 << CNT_W);
  endtask

  initial begin
    int start;
    int entry;
    int exit_e;

    pass_cnt  = 0;
    total_cnt = 0;
    cycle     = 0;
    exp_vs    = 0;
    exp_steps = 0;
    rst       = 1'b1;
    {btn_prev, btn_next, btn_mode, btn_step} = 4'b0000;
    load_words();

    // reset state
    repeat (3) tick();
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_run_active", run_active, 0);
    chk("rst_view_sel", view_sel, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_step_count", step_count, 0);
    rst = 1'b0;
    tick();
    chk("disp_after_rst", disp_data, words[0]);

    // 1: long step press gives exactly one pulse PRESS_LAT edges after the rise
    ce_log.delete();
    start = cycle;
    btn_step = 1'b1;
    repeat (10) tick();
    btn_step = 1'b0;
    repeat (12) tick();
    chk("step_pulse_count", ce_log.size(), 1);
    chk("step_latency", (ce_log.size() > 0) ? ce_log[0] - start : -1, PRESS_LAT);
    exp_steps = 1;
    chk("step_count_1", step_count, exp_steps);

    // 2: glitch shorter than the debounce window is ignored
    press(M_NEXT, $urandom_range(1, DEBOUNCE_CYC - 1), 12);
    chk("glitch_view", view_sel, exp_vs);
    // seven clean next presses walk 1..6 and wrap to 0
    for (int i = 0; i < NUM_VIEWS; i++) view_press(1'b1);
    chk("next_wrap_zero", view_sel, 0);

    // 3: prev from 0 wraps to 6; disp_data follows one cycle later
    start = cycle;
    btn_prev = 1'b1;
    repeat (PRESS_LAT - 1) tick();
    chk("prev_not_yet", view_sel, 0);
    tick();
    chk("prev_wrap", view_sel, NUM_VIEWS - 1);
    chk("prev_disp_old", disp_data, words[0]);
    tick();
    chk("prev_disp_new", disp_data, view_data[223:192]);
    btn_prev = 1'b0;
    repeat (12) tick();
    exp_vs = NUM_VIEWS - 1;

    // new probe words appear on the display one cycle later
    load_words();
    tick();
    chk("data_follow", disp_data, words[exp_vs]);

    // random walk through the views
    for (int i = 0; i < 8; i++) view_press($urandom_range(0, 1) == 1);

    // 4: enter RUN; pulses every RUN_DIV cycles; step presses ignored
    ce_log.delete();
    start = cycle;
    btn_mode = 1'b1;
    repeat (PRESS_LAT - 1) tick();
    chk("run_not_yet", run_active, 0);
    tick();
    chk("run_entered", run_active, 1);
    btn_mode = 1'b0;
    entry = start + PRESS_LAT;
    while (cycle < start + 22) tick();
    btn_step = 1'b1;
    repeat (6) tick();
    btn_step = 1'b0;
    while (cycle < start + 60) tick();
    chk("run_step_count", step_count, exp_steps + (cycle - 1 - entry) / RUN_DIV);

    // leave RUN exactly when the divider would fire: mode wins, no pulse
    start = cycle;
    press(M_MODE, 6, 14);
    exit_e = start + PRESS_LAT;
    chk("run_exit", run_active, 0);
    check_run(entry, exit_e);
    chk("step_count_after_run", step_count, exp_steps);

    // 5a: simultaneous next+prev leaves the view alone
    press(M_NEXT | M_PREV, 6, 12);
    chk("next_prev_same", view_sel, exp_vs);
    chk("next_prev_disp", disp_data, words[exp_vs]);

    // 5b: simultaneous step+mode in STEP: RUN entered, step dropped
    ce_log.delete();
    start = cycle;
    {btn_mode, btn_step} = 2'b11;
    repeat (6) tick();
    {btn_mode, btn_step} = 2'b00;
    repeat (2) tick();
    entry = start + PRESS_LAT;
    chk("both_run", run_active, 1);
    chk("both_no_ce_entry", ce_log.size(), 0);
    repeat (RUN_DIV - 1) tick();
    chk("both_no_ce_early", ce_log.size(), 0);
    tick();
    chk("both_first_run_ce", ce_log.size(), 1);
    chk("both_first_time", (ce_log.size() > 0) ? ce_log[0] : -1, entry + RUN_DIV);

    // 6: move to view 4 while running, then a one-cycle reset
    for (int i = 0; i < NUM_VIEWS && exp_vs != 4; i++) view_press(1'b1);
    chk("pre_rst_view", view_sel, 4);
    chk("pre_rst_run", run_active, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_run", run_active, 0);
    chk("mid_rst_view", view_sel, 0);
    chk("mid_rst_count", step_count, 0);
    chk("mid_rst_disp", disp_data, 0);
    chk("mid_rst_ce", cpu_ce, 0);
    rst = 1'b0;
    ce_log.delete();
    repeat (15) tick();
    chk("post_rst_no_ce", ce_log.size(), 0);
    chk("post_rst_count", step_count, 0);
    chk("post_rst_run", run_active, 0);
    chk("post_rst_disp", disp_data, words[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
